// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped timer/IO peripheral: register
// indices, TCON bit positions and the default window base.
package periph_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [2:0] IDX_TH      = 3'd0;
    localparam logic [2:0] IDX_TL      = 3'd1;
    localparam logic [2:0] IDX_TCON    = 3'd2;
    localparam logic [2:0] IDX_LED     = 3'd3;
    localparam logic [2:0] IDX_SWITCH  = 3'd4;
    localparam logic [2:0] IDX_DIGI    = 3'd5;
    localparam logic [2:0] IDX_SYSTICK = 3'd6;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

endpackage

// File: rtl/timer_core.sv
// Reloadable 32-bit up-counter with interrupt status; resolves every
// CPU-write versus hardware-update collision in one place.
module timer_core
    import periph_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic at_max;
    logic reload;
    logic hw_set;

    assign at_max = (tl == 32'hFFFF_FFFF);
    // A CPU write to TL cancels the overflow and its side effects.
    assign reload = tcon[TCON_EN] && at_max && !tl_we;
    assign hw_set = reload && tcon[TCON_IE];

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (th_we)
                th <= wdata;
            // Reload picks up the pre-edge TH even when TH is written now.
            if (tl_we)
                tl <= wdata;
            else if (tcon[TCON_EN])
                tl <= at_max ? th : tl + 32'd1;
            // The hardware status set is OR-ed in so it is never lost.
            if (tcon_we)
                tcon <= {wdata[TCON_IS] | hw_set, wdata[TCON_IE], wdata[TCON_EN]};
            else if (hw_set)
                tcon[TCON_IS] <= 1'b1;
        end
    end

    assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/peripheral_timer_io.sv
// Timer/LED/7-seg/switch peripheral on the CPU data bus: address decode,
// combinational read mux, output registers, systick and switch synchroniser.
module peripheral_timer_io
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    logic        hit;
    logic [2:0]  idx;
    logic        wr_en;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic        unused_byte_lane;

    assign hit   = (Address[31:5] == BASE_ADDR[31:5]);
    assign idx   = Address[4:2];
    assign wr_en = MemWrite && hit;
    assign unused_byte_lane = ^Address[1:0];

    timer_core u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (wr_en && (idx == IDX_TH)),
        .tl_we   (wr_en && (idx == IDX_TL)),
        .tcon_we (wr_en && (idx == IDX_TCON)),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irqout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            if (wr_en && (idx == IDX_LED))
                led <= Write_data[7:0];
            if (wr_en && (idx == IDX_DIGI))
                digi <= Write_data[11:0];
            systick <= systick + 32'd1;
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead && hit) begin
            case (idx)
                IDX_TH:      Read_data = th;
                IDX_TL:      Read_data = tl;
                IDX_TCON:    Read_data = {29'd0, tcon};
                IDX_LED:     Read_data = {24'd0, led};
                IDX_SWITCH:  Read_data = {24'd0, sw_sync};
                IDX_DIGI:    Read_data = {20'd0, digi};
                IDX_SYSTICK: Read_data = systick;
                default:     Read_data = '0;
            endcase
        end
    end

endmodule

// File: doc/peripheral_timer_io.md
# peripheral_timer_io

Memory-mapped peripheral block sharing the single-cycle CPU's data bus with the data RAM, decoding a fixed 32-byte window at `BASE_ADDR`. It contains:
- a reloadable 32-bit timer with interrupt,
- a free-running system tick counter,
- LED and 7-segment output registers,
- a synchronised switch input.

The CPU's read-data mux selects this block's `Read_data` when `Address` falls in its window. Its `irqout` feeds the CPU's interrupt logic.

## Interface
- `BASE_ADDR`, `32'h40000000`, window base; must be 32-byte aligned.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `Address`  in  32  byte address from the CPU.
- `Write_data`  in  32  store data.
- `MemRead`  in  1  load enable.
- `MemWrite`  in  1  store enable.
- `Read_data`  out  32  load data; combinational.
- `switch`  in  8  asynchronous board switches.
- `led`  out  8  LED register.
- `digi`  out  12  7-segment register: [11:8] anode select, [7:0] segments.
- `irqout`  out  1  timer interrupt request, level.

## Operation
- Hit: `Address[31:5] == BASE_ADDR[31:5]`.
- Register index is `Address[4:2]`; `Address[1:0]` is ignored.
- Register map:
  - index 0: TH, reload value, RW.
  - index 1: TL, counter, RW.
  - index 2: TCON[2:0], RW; bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status.
  - index 3: led[7:0], RW.
  - index 4: switch_sync[7:0], RO.
  - index 5: digi[11:0], RW.
  - index 6: systick, RO.
  - index 7: unmapped.
- Reads:
  - `Read_data` = zero-extended register value when `MemRead` is high and the address hits.
  - Otherwise `Read_data` = 0, including unmapped index 7 and misses.
- Writes: on the rising `clk` edge when `MemWrite` is high and the address hits.
  - Only the register's defined low bits are stored.
  - Writes to RO registers, unmapped index 7 and misses are ignored.
- Timer, each cycle with TCON[0]=1:
  - if TL == 32'hFFFFFFFF: TL <= TH, and TCON[2] <= 1 when TCON[1]=1;
  - else TL <= TL+1.
- Precedence:
  - A CPU write to TL in the same cycle as a tick: the write wins, and no overflow side effects occur that cycle.
  - A CPU write to TCON in the same cycle as an overflow: bits[1:0] take the written value; bit2 = written bit2 OR the overflow set. A hardware set is never lost.
  - A write to TH in the same cycle as a reload: TL reloads with the old TH.
- `irqout` = TCON[1] & TCON[2].
- systick increments every cycle, including during timer disable, and wraps at 2^32 to 0.
- switch passes through a 2-flop synchroniser before becoming readable.

## Timing
- Reset (synchronous, held ≥1 edge): TH, TL, TCON, led, digi, systick and both synchroniser stages all go to 0.
  - Outputs after reset: `led` = 0, `digi` = 0, `irqout` = 0.
  - `Read_data` follows its inputs combinationally even during reset.
- Reset asserted mid-count clears all state at that edge. Writes in the reset cycle are discarded.
- Read latency: 0 cycles, combinational, same cycle as `Address`/`MemRead`.
- Write latency: the register shows the new value on the cycle after the edge.
- Timer cadence: after enabling with TL=T, overflow occurs (2^32−T) edges later. `irqout` rises the cycle after that overflow edge.
- Switch latency: a switch change is visible in index 4 after 2 edges.
- No handshake: every access completes in one cycle.

## Structure
- Shared package `periph_pkg`:
  - register index constants: `IDX_TH`…`IDX_SYSTICK`;
  - TCON bit positions: `TCON_EN`, `TCON_IE`, `TCON_IS`;
  - the default base address.
- Sub-module `timer_core`:
  - ports: clk, reset, write strobes/data for TH, TL, TCON;
  - outputs: TH, TL, TCON, irq;
  - owns all precedence rules.
- The top level holds decode, the read mux, led/digi/systick and the synchroniser.

## Test plan
- **Reset:** drive reset, then read indices 0–6. Required: all reads 0, `led`=0, `digi`=0, `irqout`=0.
- **Auto-reload:** write TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, then TCON=3'b011.
  - Two edges later: TL=32'hFFFFFFF0.
  - TCON reads 3'b111; `irqout`=1.
  - Write TCON=3'b011, then `irqout`=0.
- **Simultaneous events:**
  - Write TCON=3'b011 on the overflow edge; required: TCON reads 3'b111.
  - Write TL=5 on a counting edge; required: TL reads 5 next cycle, not 6.
- **Decode:**
  - Write led=8'hA5 at 0x4000000C; required: `led`=8'hA5.
  - Write at 0x4000002C; required: no register changes.
  - Read at 0x4000001C; required: 0. Read at 0x4000000D; required: 8'hA5.
- **Switch and RO registers:**
  - Set switch=8'h3C. Required: index 4 reads 0 after 1 edge and 8'h3C after 2.
  - Write index 4 and index 6; required: values unchanged (systick keeps counting).
- **Systick:** after reset, read systick at cycle N; required: value N.
  - Assert reset mid-count with TL=100, TCON=1; required: TL=0 and systick=0 next cycle.
